// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin sharing of the UART core register port between two requesters.
module uart_bus_arbiter #(
  parameter int READ_LAT = 1,
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       uart_read,
  output logic       uart_write,
  output logic       uart_IACK,
  output logic [1:0] uart_addr,
  output logic [7:0] dout_to_uart,
  input  logic [7:0] din_from_uart,
  input  logic       uart_IRQ,
  output logic       irq,
  output logic       busy,
  output logic       owner
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, GAPS} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d, addr_q, addr_d;
  logic [7:0] dout_q, dout_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [3:0] cnt_q, cnt_d;
  logic owner_q, owner_d, gnt, ld_rd;
  logic rd_q, rd_d, wr_q, wr_d, ia_q, ia_d, ack0_q, ack0_d, ack1_q, ack1_d;
  assign gnt = (req0 & req1) ? ~owner_q : req1;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    dout_d = dout_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = ISSUE;
        owner_d = gnt;
        op_d = gnt ? op1 : op0;
        addr_d = gnt ? addr1 : addr0;
        dout_d = gnt ? wdata1 : wdata0;
      end
      ISSUE: begin
        state_d = (op_q == 2'b00 && READ_LAT > 0) ? WAIT : ACK;
        cnt_d = 4'(READ_LAT - 1);
      end
      WAIT: begin
        state_d = (cnt_q == 4'd0) ? ACK : WAIT;
        cnt_d = cnt_q - 4'd1;
      end
      ACK: begin
        state_d = (GAP > 0) ? GAPS : IDLE;
        cnt_d = 4'(GAP - 1);
      end
      GAPS: begin
        state_d = (cnt_q == 4'd0) ? IDLE : GAPS;
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // read data is captured on the edge that moves the FSM into ACK
    ld_rd = state_d == ACK && state_q != ACK && op_q == 2'b00;
    rdata0_d = (ld_rd && !owner_q) ? din_from_uart : rdata0_q;
    rdata1_d = (ld_rd && owner_q) ? din_from_uart : rdata1_q;
    rd_d = state_d == ISSUE && op_d == 2'b00;
    wr_d = state_d == ISSUE && op_d == 2'b01;
    ia_d = state_d == ISSUE && op_d == 2'b10;
    ack0_d = state_d == ACK && !owner_d;
    ack1_d = state_d == ACK && owner_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= 2'b00;
      addr_q <= 2'b00;
      dout_q <= 8'h00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
      cnt_q <= 4'd0;
      owner_q <= 1'b1;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      ia_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q <= cnt_d;
      owner_q <= owner_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      ia_q <= ia_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
    end
  end
  assign uart_read = rd_q;
  assign uart_write = wr_q;
  assign uart_IACK = ia_q;
  assign uart_addr = addr_q;
  assign dout_to_uart = dout_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign owner = owner_q;
  assign busy = state_q != IDLE;
  assign irq = uart_IRQ;
endmodule
